// File: rtl/neuron_mac.sv
// neuron_mac: per-neuron multiply-accumulate with bias, rescale and Q2.5 saturation.
// Ports: clk/reset; in_* beat stream (valid/ready, last); out_* result (valid/ready, z, sat, len).
module neuron_mac #(
  parameter int N_INPUTS = 8,
  parameter int ACC_W    = 24,
  parameter int SHIFT    = 5,
  parameter int CNT_W    = $clog2(N_INPUTS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [7:0]  in_x,
  input  logic signed [7:0]  in_w,
  input  logic signed [15:0] in_bias,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [7:0]  out_z,
  output logic               out_sat,
  output logic [CNT_W-1:0]   out_len
);

  typedef enum logic {
    S_ACC,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);
  localparam logic signed [ACC_W-1:0] Z_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] Z_MIN = -ACC_W'(128);

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    first_q, first_d;
  logic signed [7:0]       z_q, z_d;
  logic                    sat_q, sat_d;
  logic [CNT_W-1:0]        len_q, len_d;

  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] base;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] sh;
  logic                    end_beat;

  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_DONE);
  assign out_z     = z_q;
  assign out_sat   = sat_q;
  assign out_len   = len_q;

  always_comb begin
    prod     = in_x * in_w;
    base     = first_q ? {{(ACC_W-16){in_bias[15]}}, in_bias}
                       : acc_q;
    acc_sum  = base + {{(ACC_W-16){prod[15]}}, prod};
    sh       = acc_sum >>> SHIFT;
    end_beat = in_last || (cnt_q == LAST_CNT);

    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    z_d     = z_q;
    sat_d   = sat_q;
    len_d   = len_q;

    unique case (state_q)
      S_ACC: begin
        if (in_valid) begin
          acc_d   = acc_sum;
          cnt_d   = cnt_q + 1'b1;
          first_d = 1'b0;
          if (end_beat) begin
            state_d = S_DONE;
            len_d   = cnt_q + 1'b1;
            unique case (1'b1)
              (sh > Z_MAX): begin
                z_d   = 8'sd127;
                sat_d = 1'b1;
              end
              (sh < Z_MIN): begin
                z_d   = -8'sd128;
                sat_d = 1'b1;
              end
              default: begin
                z_d   = sh[7:0];
                sat_d = 1'b0;
              end
            endcase
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_ACC;
          cnt_d   = '0;
          first_d = 1'b1;
        end
      end
      default: state_d = S_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      first_q <= 1'b1;
      z_q     <= '0;
      sat_q   <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      z_q     <= z_d;
      sat_q   <= sat_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// tb_neuron_mac: directed table, hand sequences and random vectors
// against an arithmetic reference model of neuron_mac.
module tb_neuron_mac;

  localparam int N = 8;
  localparam int CW = $clog2(N + 1);

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [7:0]  in_x = '0;
  logic signed [7:0]  in_w = '0;
  logic signed [15:0] in_bias = '0;
  logic               in_last = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [7:0]  out_z;
  logic               out_sat;
  logic [CW-1:0]      out_len;

  int n_vec = 0;
  int n_err = 0;

  neuron_mac #(.N_INPUTS(N)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_w(in_w), .in_bias(in_bias),
    .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_sat(out_sat), .out_len(out_len)
  );

  always #5 clk = ~clk;

  typedef struct {
    int n; int x; int w; int bias; bit use_last;
    int z; int sat; int len;
  } vec_t;

  task automatic check(string name, int got, int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic int floor32(int s);
    int q;
    q = s / 32;
    if ((s % 32 != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  // Reference result: floor(sum/32) clipped into [-128,127].
  task automatic model(input int sum, output int z, output int sat);
    int q;
    q = floor32(sum);
    sat = (q > 127 || q < -128) ? 1 : 0;
    z = (q > 127) ? 127 : (q < -128) ? -128 : q;
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send_beat(int x, int w, int b, bit last);
    int k;
    in_x = x[7:0];
    in_w = w[7:0];
    in_bias = b[15:0];
    in_last = last;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("beat_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic get_result(string nm, int z, int sat, int len, int dly);
    int k;
    in_valid = 1'b0;
    in_last = 1'b0;
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({nm, "_valid"}, int'(out_valid), 1);
    repeat (dly) @(negedge clk);
    check({nm, "_z"}, int'(out_z), z);
    check({nm, "_sat"}, int'(out_sat), sat);
    check({nm, "_len"}, int'(out_len), len);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({nm, "_drop"}, int'(out_valid), 0);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1, 32, 32, 0, 1'b1, 32, 0, 1};
    tbl[1] = '{4, 64, 64, 0, 1'b1, 127, 1, 4};
    tbl[2] = '{2, -128, 127, 0, 1'b1, -128, 1, 2};
    tbl[3] = '{1, 0, 0, -96, 1'b1, -3, 0, 1};
    tbl[4] = '{8, 1, 32, 0, 1'b0, 8, 0, 8};
    tbl[5] = '{3, 5, -7, 100, 1'b1, -1, 0, 3};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_z", int'(out_z), 0);
    check("rst_out_sat", int'(out_sat), 0);
    check("rst_out_len", int'(out_len), 0);

    // Directed table; later beats carry junk bias that must be ignored.
    foreach (tbl[t]) begin
      for (int i = 0; i < tbl[t].n; i++) begin
        send_beat(tbl[t].x, tbl[t].w,
                  (i == 0) ? tbl[t].bias : int'($urandom_range(0, 4000)),
                  tbl[t].use_last && (i == tbl[t].n - 1));
        if (i == 0 && tbl[t].n > 1)
          check($sformatf("tbl%0d_tput", t), int'(in_ready), 1);
      end
      get_result($sformatf("tbl%0d", t), tbl[t].z, tbl[t].sat, tbl[t].len, 0);
    end

    // Backpressure: next beat held while the result waits.
    send_beat(10, 20, 0, 1'b1);
    in_x = 8'sd32;
    in_w = 8'sd32;
    in_bias = 16'sd0;
    in_last = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_z", int'(out_z), 6);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_hs_drop", int'(out_valid), 0);
    check("bp_hs_ready", int'(in_ready), 1);
    @(negedge clk);
    check("bp_next_valid", int'(out_valid), 1);
    get_result("bp_next", 32, 0, 1, 0);

    // 10 beats without last: 8 auto-close, then 2 with fresh bias.
    for (int i = 0; i < 8; i++) send_beat(1, 32, 0, 1'b0);
    get_result("nolast_a", 8, 0, 8, 0);
    send_beat(1, 32, 64, 1'b0);
    send_beat(1, 32, 999, 1'b1);
    get_result("nolast_b", 4, 0, 2, 0);

    // Reset mid-vector discards the partial sum.
    for (int i = 0; i < 3; i++) send_beat(32, 32, 0, 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_ready", int'(in_ready), 1);
    send_beat(32, 32, 0, 1'b1);
    get_result("midrst", 32, 0, 1, 0);

    // Random vectors with idle gaps and random backpressure.
    for (int v = 0; v < 60; v++) begin
      int tgt, nb, sum, b0, x, w, ez, es;
      tgt = $urandom_range(1, 9);
      nb = (tgt > N) ? N : tgt;
      b0 = int'($signed(16'($urandom)));
      sum = b0;
      for (int i = 0; i < nb; i++) begin
        x = int'($signed(8'($urandom)));
        w = int'($signed(8'($urandom)));
        sum += x * w;
        if ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          @(negedge clk);
        end
        send_beat(x, w, (i == 0) ? b0 : int'($urandom),
                  (i == tgt - 1));
      end
      model(sum, ez, es);
      get_result($sformatf("rnd%0d", v), ez, es, nb,
                 $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
